mem_access_unit: RTL
====================

# mem_access_unit

- Memory-stage access unit that consumes the EX/MEM pipeline register outputs.
- Performs data-memory loads and stores over a req/ack handshake, stalls the upstream pipeline while an access is outstanding, and presents registered results to the MEM/WB register.
- Sits between the EX/MEM register and the MEM/WB register.
- Like the pipeline registers, all state updates on the falling edge of clk.

## Interface

Parameters:
- TIMEOUT, default 15: falling edges in ACCESS without ack before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock. All state updates on the falling edge.
- rst  in  1  asynchronous, active-low reset.
- MemToReg_in, MemRead_in, MemWrite_in, RegWrite_in  in  1 each  control bits from EX/MEM.
- alu_in  in  32  address for memory ops; result otherwise.
- RD3_in  in  32  store data.
- RR3_in  in  4  destination register index.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_ack  in  1  memory completion. mem_rdata is valid while it is high.
- mem_rdata  in  32  memory read data.
- stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
- wb_valid  out  1  one-cycle pulse: outputs below carry a retiring instruction.
- MemToReg_out, RegWrite_out  out  1 each  to MEM/WB.
- mem_data_out  out  32  load data.
- alu_out  out  32  passthrough of alu_in.
- RR3_out  out  4  passthrough of RR3_in.
- err  out  1  sticky timeout flag.

## Operation

- States: IDLE, ACCESS, DONE. On rst low, state returns to IDLE.
- Reset values: every output 0; mem_req drops immediately, asynchronously.
- memop = MemRead_in | MemWrite_in.
- IDLE, memop = 0, at falling edge:
  - Register MemToReg_in, RegWrite_in, alu_in and RR3_in to the outputs.
  - Set mem_data_out = 0 and wb_valid = 1.
  - Stay in IDLE.
- IDLE, memop = 1, at falling edge:
  - Latch mem_addr = alu_in and mem_wdata = RD3_in.
  - Set mem_we = MemWrite_in; write wins if both MemRead_in and MemWrite_in are set.
  - Latch the control fields, RR3_in and alu_in.
  - Set mem_req = 1 and wb_valid = 0, then go to ACCESS.
- ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable.
  - On the first falling edge with mem_ack = 1: drop mem_req and pulse wb_valid = 1.
  - On that edge, drive the registered fields; mem_data_out = mem_rdata for a read, 0 for a write.
  - Then go to DONE.
- DONE: wb_valid = 0; go to IDLE unconditionally. EX/MEM still holds the completed op here, so it is not re-issued.
- stall = (IDLE & memop) | ACCESS. It is 0 in DONE, so EX/MEM advances on the DONE→IDLE edge.
- mem_ack is ignored outside ACCESS.
- Reset mid-ACCESS aborts the access with no wb_valid pulse; the memory must tolerate a dropped request.
- Writes retire with RegWrite_out as supplied; the unit does not alter control bits except on timeout.

## Timing

- Non-memory op: registered on the next falling edge, wb_valid = 1 for one cycle. Back-to-back ops give continuous wb_valid.
- Memory op issued at falling edge N, ack sampled high at edge N+k (k ≥ 1):
  - wb_valid is high for one cycle after edge N+k.
  - stall is high from op presentation until edge N+k.
  - The next instruction is accepted at edge N+k+1.
- Minimum memory-op occupancy is 3 edges: issue, ack, DONE.
- Memory must hold mem_rdata valid while mem_ack is high at the sampling edge.

## Configuration

- MEM_TIMEOUT_EN defined:
  - A 4-bit wait counter clears at issue and increments each ACCESS edge without ack.
  - On reaching TIMEOUT: drop mem_req, pulse wb_valid with RegWrite_out = 0 and mem_data_out = 0, set err = 1 (sticky until rst), go to DONE.
- Undefined: no counter; ACCESS waits indefinitely and err is tied 0.

## Test plan

- ALU op with alu_in = 0x1234, RR3_in = 5, RegWrite_in = 1 → next edge: wb_valid = 1, alu_out = 0x1234, RR3_out = 5, stall never asserted.
- Load at alu_in = 0x40, ack after 3 wait edges with mem_rdata = 0xDEADBEEF → stall high 4 edges, mem_data_out = 0xDEADBEEF, a single wb_valid pulse.
- Store with MemRead_in = MemWrite_in = 1, RD3_in = 0xA5A5A5A5 → mem_we = 1, mem_wdata = 0xA5A5A5A5, mem_data_out = 0.
- rst low during ACCESS → mem_req = 0 immediately, no wb_valid; after release, IDLE and all outputs 0.
- Ack held high continuously across two back-to-back loads → each retires exactly once, with DONE between them.
- MEM_TIMEOUT_EN, TIMEOUT = 15, ack never asserted → abort at edge 15, wb_valid = 1, RegWrite_out = 0, err = 1 and stays high until rst.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: issues loads/stores over a req/ack handshake, stalls upstream while busy,
// and presents registered results to MEM/WB on the falling edge. Optional abort timer: MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemToReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        RegWrite_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] RD3_in,
    input  logic [3:0]  RR3_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic        MemToReg_out,
    output logic        RegWrite_out,
    output logic [31:0] mem_data_out,
    output logic [31:0] alu_out,
    output logic [3:0]  RR3_out,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_reg, state_next;
    logic        req_reg, req_next;
    logic        we_reg, we_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        wb_valid_reg, wb_valid_next;
    logic        memtoreg_reg, memtoreg_next;
    logic        regwrite_reg, regwrite_next;
    logic [31:0] data_reg, data_next;
    logic [31:0] alu_reg, alu_next;
    logic [3:0]  rr3_reg, rr3_next;
    // Fields of the in-flight memory op, held until it retires.
    logic        memtoreg_hold_reg, memtoreg_hold_next;
    logic        regwrite_hold_reg, regwrite_hold_next;
    logic [31:0] alu_hold_reg, alu_hold_next;
    logic [3:0]  rr3_hold_reg, rr3_hold_next;
`ifdef MEM_TIMEOUT_EN
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic        err_reg, err_next;
`endif

    logic memop;
    assign memop = MemRead_in | MemWrite_in;

    always_comb begin
        state_next         = state_reg;
        req_next           = req_reg;
        we_next            = we_reg;
        addr_next          = addr_reg;
        wdata_next         = wdata_reg;
        wb_valid_next      = 1'b0;
        memtoreg_next      = memtoreg_reg;
        regwrite_next      = regwrite_reg;
        data_next          = data_reg;
        alu_next           = alu_reg;
        rr3_next           = rr3_reg;
        memtoreg_hold_next = memtoreg_hold_reg;
        regwrite_hold_next = regwrite_hold_reg;
        alu_hold_next      = alu_hold_reg;
        rr3_hold_next      = rr3_hold_reg;
`ifdef MEM_TIMEOUT_EN
        wait_cnt_next      = wait_cnt_reg;
        err_next           = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (!memop) begin
                    memtoreg_next = MemToReg_in;
                    regwrite_next = RegWrite_in;
                    alu_next      = alu_in;
                    rr3_next      = RR3_in;
                    data_next     = 32'd0;
                    wb_valid_next = 1'b1;
                end else begin
                    addr_next          = alu_in;
                    wdata_next         = RD3_in;
                    we_next            = MemWrite_in;
                    memtoreg_hold_next = MemToReg_in;
                    regwrite_hold_next = RegWrite_in;
                    alu_hold_next      = alu_in;
                    rr3_hold_next      = RR3_in;
                    req_next           = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    wait_cnt_next      = 4'd0;
`endif
                    state_next         = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    req_next      = 1'b0;
                    wb_valid_next = 1'b1;
                    memtoreg_next = memtoreg_hold_reg;
                    regwrite_next = regwrite_hold_reg;
                    alu_next      = alu_hold_reg;
                    rr3_next      = rr3_hold_reg;
                    data_next     = we_reg ? 32'd0 : mem_rdata;
                    state_next    = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                // Abort retires the op as a harmless no-writeback instruction.
                else if (({1'b0, wait_cnt_reg} + 5'd1) == 5'(TIMEOUT)) begin
                    req_next      = 1'b0;
                    wb_valid_next = 1'b1;
                    memtoreg_next = memtoreg_hold_reg;
                    regwrite_next = 1'b0;
                    alu_next      = alu_hold_reg;
                    rr3_next      = rr3_hold_reg;
                    data_next     = 32'd0;
                    err_next      = 1'b1;
                    state_next    = DONE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
`endif
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= IDLE;
            req_reg           <= 1'b0;
            we_reg            <= 1'b0;
            addr_reg          <= 32'd0;
            wdata_reg         <= 32'd0;
            wb_valid_reg      <= 1'b0;
            memtoreg_reg      <= 1'b0;
            regwrite_reg      <= 1'b0;
            data_reg          <= 32'd0;
            alu_reg           <= 32'd0;
            rr3_reg           <= 4'd0;
            memtoreg_hold_reg <= 1'b0;
            regwrite_hold_reg <= 1'b0;
            alu_hold_reg      <= 32'd0;
            rr3_hold_reg      <= 4'd0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_reg      <= 4'd0;
            err_reg           <= 1'b0;
`endif
        end else begin
            state_reg         <= state_next;
            req_reg           <= req_next;
            we_reg            <= we_next;
            addr_reg          <= addr_next;
            wdata_reg         <= wdata_next;
            wb_valid_reg      <= wb_valid_next;
            memtoreg_reg      <= memtoreg_next;
            regwrite_reg      <= regwrite_next;
            data_reg          <= data_next;
            alu_reg           <= alu_next;
            rr3_reg           <= rr3_next;
            memtoreg_hold_reg <= memtoreg_hold_next;
            regwrite_hold_reg <= regwrite_hold_next;
            alu_hold_reg      <= alu_hold_next;
            rr3_hold_reg      <= rr3_hold_next;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_reg      <= wait_cnt_next;
            err_reg           <= err_next;
`endif
        end
    end

    // Stall drops in DONE so EX/MEM advances on the DONE->IDLE edge.
    assign stall        = ((state_reg == IDLE) && memop) || (state_reg == ACCESS);
    assign mem_req      = req_reg;
    assign mem_we       = we_reg;
    assign mem_addr     = addr_reg;
    assign mem_wdata    = wdata_reg;
    assign wb_valid     = wb_valid_reg;
    assign MemToReg_out = memtoreg_reg;
    assign RegWrite_out = regwrite_reg;
    assign mem_data_out = data_reg;
    assign alu_out      = alu_reg;
    assign RR3_out      = rr3_reg;
`ifdef MEM_TIMEOUT_EN
    assign err          = err_reg;
`else
    assign err          = 1'b0;
`endif

endmodule
